// File: rtl/zoom_address_generator.sv
// Zoom address generator: walks the output frame, fetches source pixels (NN/PR/DC
// single fetch, BA 2x2 average) and writes one destination pixel per output position.
module zoom_address_generator #(
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120,
    parameter int DATA_W        = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [1:0]        ALGORITHM,
    input  logic [1:0]        SHIFT_FACTOR,
    input  logic [10:0]       IMG_WIDTH_OUT,
    input  logic [9:0]        IMG_HEIGHT_OUT,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              RD_EN,
    output logic [14:0]       RD_ADDR,
    output logic              WR_EN,
    output logic [20:0]       WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    localparam logic [1:0]  ALG_DC     = 2'b10;
    localparam logic [1:0]  ALG_BA     = 2'b11;
    localparam logic [31:0] W_IN       = 32'(IMG_WIDTH_IN);
    localparam logic [31:0] SRC_PIXELS = 32'(IMG_WIDTH_IN * IMG_HEIGHT_IN);

    logic [2:0]        r_state;
    logic [1:0]        r_alg;
    logic [1:0]        r_shift;
    logic [10:0]       r_width;
    logic [9:0]        r_height;
    logic [10:0]       r_x;
    logic [9:0]        r_y;
    logic [1:0]        r_k;
    logic [DATA_W+1:0] r_acc;
    logic [20:0]       r_wr_cnt;
    logic [14:0]       r_rd_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_x_last;
    logic              w_y_last;
    logic [10:0]       w_x_next;
    logic [9:0]        w_y_next;
    logic [DATA_W+1:0] w_acc_sum;
    logic              w_is_ba;

    // Full 32-bit arithmetic; addresses past the source frame saturate to its last pixel.
    function automatic logic [31:0] src_addr(input logic [1:0] alg, input logic [1:0] s,
                                             input logic [10:0] x, input logic [9:0] y,
                                             input logic [1:0] k);
        logic [31:0] xx;
        logic [31:0] yy;
        logic [31:0] a;
        xx = {21'd0, x};
        yy = {22'd0, y};
        case (alg)
            ALG_DC:  a = (yy << s) * W_IN + (xx << s);
            ALG_BA:  a = (yy << 1) * W_IN + (xx << 1) + (k[1] ? W_IN : 32'd0) + {31'd0, k[0]};
            default: a = (yy >> s) * W_IN + (xx >> s);
        endcase
        if (a >= SRC_PIXELS) begin
            a = SRC_PIXELS - 32'd1;
        end
        return a;
    endfunction

    assign w_x_last  = (r_x == r_width - 11'd1);
    assign w_y_last  = (r_y == r_height - 10'd1);
    assign w_x_next  = w_x_last ? 11'd0 : r_x + 11'd1;
    assign w_y_next  = w_x_last ? r_y + 10'd1 : r_y;
    assign w_acc_sum = r_acc + {2'b00, RD_DATA};
    assign w_is_ba   = (r_alg == ALG_BA);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_alg     <= 2'd0;
            r_shift   <= 2'd0;
            r_width   <= 11'd0;
            r_height  <= 10'd0;
            r_x       <= 11'd0;
            r_y       <= 10'd0;
            r_k       <= 2'd0;
            r_acc     <= '0;
            r_wr_cnt  <= 21'd0;
            r_rd_addr <= 15'd0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_alg    <= ALGORITHM;
                        r_shift  <= SHIFT_FACTOR;
                        r_width  <= IMG_WIDTH_OUT;
                        r_height <= IMG_HEIGHT_OUT;
                        r_x      <= 11'd0;
                        r_y      <= 10'd0;
                        r_k      <= 2'd0;
                        r_acc    <= '0;
                        r_wr_cnt <= 21'd0;
                        if (IMG_WIDTH_OUT == 11'd0 || IMG_HEIGHT_OUT == 10'd0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_rd_addr <= 15'(src_addr(ALGORITHM, SHIFT_FACTOR, 11'd0, 10'd0, 2'd0));
                            r_state   <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_acc <= w_acc_sum;
                    if (w_is_ba && r_k != 2'd3) begin
                        r_k       <= r_k + 2'd1;
                        r_rd_addr <= 15'(src_addr(r_alg, r_shift, r_x, r_y, r_k + 2'd1));
                        r_state   <= S_READ;
                    end else begin
                        r_wr_data <= w_is_ba ? w_acc_sum[DATA_W+1:2] : RD_DATA;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_wr_cnt <= r_wr_cnt + 21'd1;
                    r_acc    <= '0;
                    r_k      <= 2'd0;
                    r_x      <= w_x_next;
                    r_y      <= w_y_next;
                    if (w_x_last && w_y_last) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_rd_addr <= 15'(src_addr(r_alg, r_shift, w_x_next, w_y_next, 2'd0));
                        r_state   <= S_READ;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign RD_EN   = (r_state == S_READ);
    assign WR_EN   = (r_state == S_WRITE);
    assign BUSY    = (r_state != S_IDLE);
    assign DONE    = (r_state == S_FINISH);
    assign RD_ADDR = r_rd_addr;
    assign WR_ADDR = r_wr_cnt;
    assign WR_DATA = r_wr_data;

endmodule

// File: tb/tb_zoom_address_generator.sv
// Directed bench for zoom_address_generator: source RAM model, bus monitor and
// hand-computed expectations for each scenario.
module tb_zoom_address_generator;

    localparam int SRC = 19200;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [1:0]  ALGORITHM;
    logic [1:0]  SHIFT_FACTOR;
    logic [10:0] IMG_WIDTH_OUT;
    logic [9:0]  IMG_HEIGHT_OUT;
    logic [7:0]  RD_DATA = 8'd0;
    logic        RD_EN;
    logic [14:0] RD_ADDR;
    logic        WR_EN;
    logic [20:0] WR_ADDR;
    logic [7:0]  WR_DATA;
    logic        BUSY;
    logic        DONE;

    zoom_address_generator #(
        .IMG_WIDTH_IN (160),
        .IMG_HEIGHT_IN(120),
        .DATA_W       (8)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .START         (START),
        .ALGORITHM     (ALGORITHM),
        .SHIFT_FACTOR  (SHIFT_FACTOR),
        .IMG_WIDTH_OUT (IMG_WIDTH_OUT),
        .IMG_HEIGHT_OUT(IMG_HEIGHT_OUT),
        .RD_DATA       (RD_DATA),
        .RD_EN         (RD_EN),
        .RD_ADDR       (RD_ADDR),
        .WR_EN         (WR_EN),
        .WR_ADDR       (WR_ADDR),
        .WR_DATA       (WR_DATA),
        .BUSY          (BUSY),
        .DONE          (DONE)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [0:SRC-1];

    always @(posedge CLK) begin
        if (RD_EN) RD_DATA <= (int'(RD_ADDR) < SRC) ? mem[RD_ADDR] : 8'd0;
    end

    // Monitor state (written only by the monitor process)
    int          m_rd, m_wr, m_seq_err, m_rdwr_err, m_data_err, m_both, m_done, m_busy, m_phit;
    int          frame_idx;
    logic [14:0] rd_h [4];
    logic [14:0] l_rd [4];
    logic [14:0] p_rd [4];
    int          l_wr_addr;
    logic [7:0]  l_data, p_data;

    // Monitor controls (written only by the stimulus process)
    bit chk_rdwr, chk_data;
    int probe;

    always @(negedge CLK) begin
        if (RD_EN) begin
            rd_h[3] = rd_h[2];
            rd_h[2] = rd_h[1];
            rd_h[1] = rd_h[0];
            rd_h[0] = RD_ADDR;
            m_rd++;
        end
        if (WR_EN) begin
            m_wr++;
            if (int'(WR_ADDR) != frame_idx) m_seq_err++;
            frame_idx++;
            if (chk_rdwr && int'(rd_h[0]) != int'(WR_ADDR)) m_rdwr_err++;
            if (chk_data && (int'(rd_h[0]) >= SRC || WR_DATA != mem[rd_h[0]])) m_data_err++;
            l_wr_addr = int'(WR_ADDR);
            l_data    = WR_DATA;
            for (int j = 0; j < 4; j++) l_rd[j] = rd_h[j];
            if (int'(WR_ADDR) == probe) begin
                m_phit++;
                p_data = WR_DATA;
                for (int j = 0; j < 4; j++) p_rd[j] = rd_h[j];
            end
        end
        if (RD_EN && WR_EN) m_both++;
        if (DONE) m_done++;
        if (BUSY) m_busy++;
        if (!BUSY) frame_idx = 0;
    end

    int n_total = 0;
    int n_bad   = 0;
    int b_rd, b_wr, b_seq, b_rdwr, b_data, b_both, b_done, b_busy, b_phit;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic snap();
        b_rd = m_rd; b_wr = m_wr; b_seq = m_seq_err; b_rdwr = m_rdwr_err;
        b_data = m_data_err; b_both = m_both; b_done = m_done; b_busy = m_busy; b_phit = m_phit;
    endtask

    task automatic start_frame(input logic [1:0] alg, input logic [1:0] s,
                               input logic [10:0] w, input logic [9:0] h);
        ALGORITHM = alg; SHIFT_FACTOR = s; IMG_WIDTH_OUT = w; IMG_HEIGHT_OUT = h;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (DONE) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    bit ok;
    int exp_ba;

    initial begin
        RESET_N = 1'b0; START = 1'b0; ALGORITHM = 2'd0; SHIFT_FACTOR = 2'd0;
        IMG_WIDTH_OUT = 11'd0; IMG_HEIGHT_OUT = 10'd0;
        chk_rdwr = 1'b0; chk_data = 1'b0; probe = -1;
        for (int i = 0; i < SRC; i++) mem[i] = 8'((i * 7 + 3) ^ (i >> 8));
        mem[0] = 8'd10; mem[1] = 8'd20; mem[160] = 8'd30; mem[161] = 8'd41;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_strobes", int'({RD_EN, WR_EN, DONE}), 0);
        chk("rst_rd_addr", int'(RD_ADDR), 0);
        chk("rst_wr_addr", int'(WR_ADDR), 0);
        chk("rst_wr_data", int'(WR_DATA), 0);
        RESET_N = 1'b1;
        repeat (3) tick();
        chk("idle_without_start", int'(BUSY), 0);

        // NN s=0 full 160x120 frame
        chk_rdwr = 1'b1; chk_data = 1'b1;
        snap();
        start_frame(2'b00, 2'd0, 11'd160, 10'd120);
        wait_done(60000, ok);
        chk("nn_done_seen", int'(ok), 1);
        repeat (3) tick();
        chk("nn_writes", m_wr - b_wr, 19200);
        chk("nn_wr_seq_err", m_seq_err - b_seq, 0);
        chk("nn_rd_eq_wr_err", m_rdwr_err - b_rdwr, 0);
        chk("nn_data_err", m_data_err - b_data, 0);
        chk("nn_done_cnt", m_done - b_done, 1);
        chk("nn_frame_len", m_busy - b_busy + 1, 57602);
        chk("nn_last_wr_addr", l_wr_addr, 19199);
        chk("nn_rd_wr_overlap", m_both - b_both, 0);
        chk_rdwr = 1'b0;

        // NN s=1 320x240: pixel (3,5), then abort with reset
        probe = 1603;
        snap();
        start_frame(2'b00, 2'd1, 11'd320, 10'd240);
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (m_phit != b_phit) break;
        end
        chk("nn2_probe_hit", m_phit - b_phit, 1);
        chk("nn2_rd_addr", int'(p_rd[0]), 321);
        chk("nn2_data_err", m_data_err - b_data, 0);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
        chk("nn2_abort_idle", int'(BUSY), 0);

        // DC s=1 80x60
        probe = 81;
        snap();
        start_frame(2'b10, 2'd1, 11'd80, 10'd60);
        wait_done(16000, ok);
        chk("dc_done_seen", int'(ok), 1);
        repeat (3) tick();
        chk("dc_writes", m_wr - b_wr, 4800);
        chk("dc_rd_addr_1_1", int'(p_rd[0]), 322);
        chk("dc_wr_seq_err", m_seq_err - b_seq, 0);
        chk("dc_data_err", m_data_err - b_data, 0);
        chk("dc_done_cnt", m_done - b_done, 1);

        // BA s=1, 2x2 output
        chk_data = 1'b0;
        probe = 0;
        snap();
        start_frame(2'b11, 2'd1, 11'd2, 10'd2);
        wait_done(200, ok);
        chk("ba_done_seen", int'(ok), 1);
        repeat (3) tick();
        chk("ba_rd0", int'(p_rd[3]), 0);
        chk("ba_rd1", int'(p_rd[2]), 1);
        chk("ba_rd2", int'(p_rd[1]), 160);
        chk("ba_rd3", int'(p_rd[0]), 161);
        chk("ba_wr_data_0", int'(p_data), 25);
        chk("ba_writes", m_wr - b_wr, 4);
        chk("ba_frame_len", m_busy - b_busy + 1, 38);
        exp_ba = (int'(mem[322]) + int'(mem[323]) + int'(mem[482]) + int'(mem[483])) / 4;
        chk("ba_last_base", int'(l_rd[3]), 322);
        chk("ba_last_data", int'(l_data), exp_ba);

        // Mid-frame START and input changes are ignored
        chk_data = 1'b1;
        probe = 31;
        snap();
        start_frame(2'b00, 2'd0, 11'd8, 10'd4);
        repeat (20) tick();
        START = 1'b1; SHIFT_FACTOR = 2'd2; ALGORITHM = 2'b10; IMG_WIDTH_OUT = 11'd4;
        tick();
        START = 1'b0;
        wait_done(500, ok);
        chk("mid_done_seen", int'(ok), 1);
        repeat (3) tick();
        chk("mid_writes", m_wr - b_wr, 32);
        chk("mid_last_rd_addr", int'(p_rd[0]), 487);
        chk("mid_data_err", m_data_err - b_data, 0);
        chk("mid_done_cnt", m_done - b_done, 1);

        // START held high across FINISH: one idle cycle, then a new frame
        snap();
        ALGORITHM = 2'b00; SHIFT_FACTOR = 2'd0; IMG_WIDTH_OUT = 11'd2; IMG_HEIGHT_OUT = 10'd1;
        START = 1'b1;
        wait_done(50, ok);
        chk("hold_done_seen", int'(ok), 1);
        tick();
        chk("hold_finish_to_idle", int'(BUSY), 0);
        tick();
        chk("hold_restart", int'(BUSY), 1);
        START = 1'b0;
        wait_done(50, ok);
        repeat (3) tick();
        chk("hold_writes", m_wr - b_wr, 4);
        chk("hold_done_cnt", m_done - b_done, 2);

        // Zero width: straight to FINISH
        snap();
        start_frame(2'b00, 2'd0, 11'd0, 10'd5);
        repeat (4) tick();
        chk("zero_reads", m_rd - b_rd, 0);
        chk("zero_writes", m_wr - b_wr, 0);
        chk("zero_done_cnt", m_done - b_done, 1);

        // Reset after 100 writes aborts the frame; a new START restarts at 0
        snap();
        start_frame(2'b00, 2'd0, 11'd20, 10'd10);
        for (int i = 0; i < 1000; i++) begin
            if (m_wr - b_wr >= 100) break;
            tick();
        end
        chk("rst100_reached", m_wr - b_wr, 100);
        RESET_N = 1'b0;
        tick();
        chk("rst100_idle", int'(BUSY), 0);
        chk("rst100_no_wr", int'(WR_EN), 0);
        RESET_N = 1'b1;
        repeat (20) tick();
        chk("rst100_writes_frozen", m_wr - b_wr, 100);
        chk("rst100_no_done", m_done - b_done, 0);
        chk("rst100_stays_idle", int'(BUSY), 0);
        snap();
        start_frame(2'b00, 2'd0, 11'd20, 10'd10);
        wait_done(1000, ok);
        chk("rst100_restart_done", int'(ok), 1);
        repeat (3) tick();
        chk("rst100_restart_writes", m_wr - b_wr, 200);
        chk("rst100_restart_seq_err", m_seq_err - b_seq, 0);
        chk("rst100_restart_done_cnt", m_done - b_done, 1);
        chk("total_rd_wr_overlap", m_both, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/zoom_address_generator.md
ZOOM_ADDRESS_GENERATOR -- requirements
Module: zoom_address_generator

Interface
REQ-001 SHALL have parameter IMG_WIDTH_IN, default 160, source frame width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT_IN, default 120, source frame height in pixels.
REQ-003 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-004 SHALL have port CLK  input  1  the single clock, rising-edge.
REQ-005 SHALL have port RESET_N  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port START  input  1  frame start request, level-sampled.
REQ-007 SHALL have port ALGORITHM  input  2  00 NN, 01 PR, 10 DC, 11 BA.
REQ-008 SHALL have port SHIFT_FACTOR  input  2  log2 of the zoom factor from the resolution controller.
REQ-009 SHALL have port IMG_WIDTH_OUT  input  11  output frame width.
REQ-010 SHALL have port IMG_HEIGHT_OUT  input  10  output frame height.
REQ-011 SHALL have port RD_DATA  input  DATA_W  source pixel, valid one cycle after RD_EN.
REQ-012 SHALL have port RD_EN  output  1  source read strobe.
REQ-013 SHALL have port RD_ADDR  output  15  source linear address.
REQ-014 SHALL have port WR_EN  output  1  destination write strobe.
REQ-015 SHALL have port WR_ADDR  output  21  destination linear address.
REQ-016 SHALL have port WR_DATA  output  DATA_W  destination pixel.
REQ-017 SHALL have port BUSY  output  1  frame in progress.
REQ-018 SHALL have port DONE  output  1  one-cycle end-of-frame pulse.

Function
REQ-019 SHALL implement FSM states IDLE, READ, CAPTURE, WRITE, FINISH.
REQ-020 Transition: IDLE with START=1 -> latch ALGORITHM, SHIFT_FACTOR, IMG_WIDTH_OUT and IMG_HEIGHT_OUT; clear x, y, WR_ADDR counter and accumulator; -> READ.
REQ-021 Inputs changing after the latch SHALL have no effect until the next frame.
REQ-022 START SHALL be ignored while BUSY=1.
REQ-023 Zero latched width or height SHALL go IDLE -> FINISH with no RD_EN or WR_EN.
REQ-024 READ SHALL assert RD_EN for exactly one cycle with RD_ADDR valid, then -> CAPTURE.
REQ-025 CAPTURE SHALL register RD_DATA.
REQ-026 NN/PR source address SHALL be (y>>s)*IMG_WIDTH_IN + (x>>s), where s is the latched SHIFT_FACTOR.
REQ-027 DC source address SHALL be (y<<s)*IMG_WIDTH_IN + (x<<s).
REQ-028 NN/PR/DC SHALL use one READ and one CAPTURE per output pixel, then -> WRITE, with WR_DATA = the captured pixel.
REQ-029 BA SHALL always use a 2x2 block, regardless of s.
REQ-030 BA SHALL set base = (2y)*IMG_WIDTH_IN + 2x.
REQ-031 BA SHALL read base, base+1, base+IMG_WIDTH_IN and base+IMG_WIDTH_IN+1 in that order.
REQ-032 BA SHALL use four READ/CAPTURE pairs per output pixel, summing into a DATA_W+2-bit accumulator, then -> WRITE.
REQ-033 BA WR_DATA SHALL be accumulator>>2, truncated.
REQ-034 Per-pixel latency: 3 cycles for NN/PR/DC (READ, CAPTURE, WRITE); 9 cycles for BA.
REQ-035 WRITE SHALL assert WR_EN for exactly one cycle, with WR_ADDR = linear output counter = y*IMG_WIDTH_OUT + x.
REQ-036 After WRITE the counter SHALL increment and x SHALL increment.
REQ-037 At x = width-1, x SHALL wrap to 0 and y SHALL increment.
REQ-038 At the last pixel (x = width-1, y = height-1) WRITE SHALL go -> FINISH; otherwise -> READ.
REQ-039 FINISH SHALL assert DONE for one cycle, then -> IDLE.
REQ-040 BUSY SHALL be 1 in READ, CAPTURE, WRITE and FINISH, and 0 in IDLE.
REQ-041 RD_EN and WR_EN SHALL never be asserted in the same cycle.
REQ-042 RD_ADDR SHALL be held stable outside READ.
REQ-043 Address arithmetic SHALL be full-width, without overflow, for a 1280x960 output at s=3.
REQ-044 START=1 in the FINISH cycle SHALL be ignored; START still high in IDLE on the next cycle SHALL begin a new frame.

Reset
REQ-045 RESET_N=0 at a rising CLK edge SHALL force IDLE, with all counters, accumulator, RD_ADDR, WR_ADDR and WR_DATA at 0.
REQ-046 During reset, RD_EN, WR_EN, BUSY and DONE SHALL be 0.
REQ-047 Reset SHALL take priority over every FSM transition, including mid-frame, where it aborts the frame without issuing DONE.
REQ-048 After RESET_N returns high, the block SHALL stay IDLE until a new START.

Verification
REQ-049 NN, s=0, 160x120, START pulse -> exactly 19200 WR_EN pulses; WR_ADDR 0..19199; each RD_ADDR equals its WR_ADDR; DONE once; frame length 57600+2 cycles.
REQ-050 NN, s=1, 320x240 -> output (x=3,y=5) reads RD_ADDR 321 and writes WR_ADDR 1603.
REQ-051 DC, s=1, 80x60 -> output (1,1) reads RD_ADDR 322 and writes WR_ADDR 81; 4800 writes total.
REQ-052 BA, s=1, source block at base 0 holding 10,20,30,41 -> RD_ADDR 0,1,160,161; WR_DATA=25 at WR_ADDR 0.
REQ-053 START pulsed again mid-frame, and SHIFT_FACTOR changed mid-frame -> no restart; write count unchanged.
REQ-054 RESET_N low for 1 cycle after 100 writes -> IDLE next cycle; no further WR_EN; no DONE; a new START restarts at WR_ADDR 0.
